// File: rtl/ex_alu_stage.sv
// ex_alu_stage: registered execute-stage ALU feeding a 2-entry in-order skid buffer.
// Entry 0 is always the head, so the outputs keep their last values once the buffer drains.
module ex_alu_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [REGW-1:0]  dst_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_illegal,
  output logic [REGW-1:0]  out_dst
);
  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             ovf;
    logic             ill;
    logic [REGW-1:0]  dst;
  } ent_t;
  ent_t e0_q, e0_d, e1_q, e1_d, new_e;
  logic [1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum, diff;
  logic push, pop;
  assign in_ready  = cnt_q != 2'd2;
  assign out_valid = cnt_q != 2'd0;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign sum       = src_a + src_b;
  assign diff      = src_a - src_b;
  always_comb begin
    new_e     = '0;
    new_e.dst = dst_in;
    case (alu_ctl)
      4'b0000: new_e.res = src_a & src_b;
      4'b0001: new_e.res = src_a | src_b;
      4'b1100: new_e.res = ~(src_a | src_b);
      4'b0010: begin
        new_e.res = sum;
        new_e.ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) & (sum[WIDTH-1] != src_a[WIDTH-1]);
      end
      4'b0110: begin
        new_e.res = diff;
        new_e.ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) & (diff[WIDTH-1] != src_a[WIDTH-1]);
      end
      // signed compare directly rather than via diff's sign, which is wrong on overflow
      4'b0111: new_e.res = WIDTH'($signed(src_a) < $signed(src_b));
      default: new_e.ill = 1'b1;
    endcase
    new_e.zero = new_e.res == '0;
  end
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = flush ? 2'd0 : cnt_q + 2'(push) - 2'(pop);
    if (pop && cnt_q == 2'd2) e0_d = e1_q;
    if (push && (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop))) e0_d = new_e;
    else if (push) e1_d = new_e;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end
  assign out_result  = e0_q.res;
  assign out_zero    = e0_q.zero;
  assign out_ovf     = e0_q.ovf;
  assign out_illegal = e0_q.ill;
  assign out_dst     = e0_q.dst;
endmodule

// File: tb/tb_ex_alu_stage.sv
// tb_ex_alu_stage: scoreboard bench for ex_alu_stage with a longint-arithmetic reference model.
module tb_ex_alu_stage;
  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        ill;
    logic [4:0]  dst;
  } exp_t;
  localparam longint MAXS = 64'sh7FFF_FFFF;
  localparam longint MINS = -MAXS - 1;
  logic clk = 0, rst_n = 0;
  logic [3:0] alu_ctl = 0;
  logic [31:0] src_a = 0, src_b = 0;
  logic [4:0] dst_in = 0;
  logic in_valid = 0, flush = 0, out_ready = 0;
  logic in_ready, out_valid, out_zero, out_ovf, out_illegal;
  logic [31:0] out_result;
  logic [4:0] out_dst;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, delivered = 0;
  ex_alu_stage dut (
    .clk(clk), .rst_n(rst_n), .alu_ctl(alu_ctl), .src_a(src_a), .src_b(src_b),
    .dst_in(dst_in), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_illegal(out_illegal), .out_dst(out_dst)
  );
  always #5 clk = ~clk;
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, b, input logic [4:0] d);
    exp_t e;
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e = '0;
    e.dst = d;
    case (c)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b1100: e.res = ~(a | b);
      4'b0010: begin s = sa + sb; e.res = s[31:0]; e.ovf = s > MAXS || s < MINS; end
      4'b0110: begin s = sa - sb; e.res = s[31:0]; e.ovf = s > MAXS || s < MINS; end
      4'b0111: e.res = (sa < sb) ? 32'd1 : 32'd0;
      default: e.ill = 1'b1;
    endcase
    e.zero = e.res == 32'd0;
    return e;
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (rst_n) begin
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(model(alu_ctl, src_a, src_b, dst_in));
    end
  always @(negedge clk)
    if (rst_n && out_valid && out_ready && !flush) begin
      exp_t act;
      act = {out_result, out_zero, out_ovf, out_illegal, out_dst};
      delivered++;
      if (q.size() == 0) check("unexpected_delivery", 64'(act), 64'hDEAD);
      else check("delivery", 64'(act), 64'(q.pop_front()));
    end
  task automatic cycle(input logic [3:0] c, input logic [31:0] a, b, input logic [4:0] d,
                       input logic v, fl, rdy, output logic acc);
    alu_ctl = c; src_a = a; src_b = b; dst_in = d;
    in_valid = v; flush = fl; out_ready = rdy;
    acc = v && in_ready && !fl;
    @(posedge clk);
    #1;
    check("in_ready", 64'(in_ready), 64'(q.size() < 2));
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
  endtask
  task automatic idle(input logic rdy);
    logic acc;
    cycle(4'b0000, 0, 0, 0, 1'b0, 1'b0, rdy, acc);
  endtask
  task automatic dir(input logic [3:0] c, input logic [31:0] a, b, input logic [4:0] d,
                     input logic [31:0] r, input logic z, o, il);
    logic acc;
    cycle(c, a, b, d, 1'b1, 1'b0, 1'b1, acc);
    check("dir_result", 64'(out_result), 64'(r));
    check("dir_flags", 64'({out_zero, out_ovf, out_illegal}), 64'({z, o, il}));
    check("dir_dst", 64'(out_dst), 64'(d));
    idle(1'b1);
  endtask
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic acc;
    int base, n;
    logic [3:0] legal [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    logic [31:0] edges [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    #12;
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_in_ready", 64'(in_ready), 1);
    check("rst_outputs", 64'({out_result, out_zero, out_ovf, out_illegal, out_dst}), 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk) #1;
    dir(4'b0010, 5, 7, 3, 12, 0, 0, 0);
    dir(4'b0110, 9, 9, 4, 0, 1, 0, 0);
    dir(4'b0010, 32'h7FFF_FFFF, 1, 5, 32'h8000_0000, 0, 1, 0);
    dir(4'b0110, 32'h8000_0000, 1, 6, 32'h7FFF_FFFF, 0, 1, 0);
    dir(4'b0111, 32'hFFFF_FFFF, 1, 7, 1, 0, 0, 0);
    dir(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 8, 0, 1, 0, 0);
    dir(4'b1100, 0, 0, 9, 32'hFFFF_FFFF, 0, 0, 0);
    dir(4'b0011, 5, 5, 10, 0, 1, 0, 1);
    base = delivered;
    cycle(4'b0001, 1, 0, 1, 1'b1, 1'b0, 1'b0, acc);
    cycle(4'b0001, 2, 0, 2, 1'b1, 1'b0, 1'b0, acc);
    cycle(4'b0001, 3, 0, 3, 1'b1, 1'b0, 1'b0, acc);
    check("bp_third_held", 64'(acc), 0);
    n = 0;
    do begin cycle(4'b0001, 3, 0, 3, 1'b1, 1'b0, 1'b1, acc); n++; end while (!acc && n < 5);
    check("bp_third_accepted", 64'(acc), 1);
    n = 0;
    while (q.size() > 0 && n < 10) begin idle(1'b1); n++; end
    check("bp_delivered", 64'(delivered - base), 3);
    cycle(4'b0010, 1, 1, 11, 1'b1, 1'b0, 1'b0, acc);
    cycle(4'b0010, 2, 2, 12, 1'b1, 1'b0, 1'b0, acc);
    base = delivered;
    cycle(4'b0010, 3, 3, 13, 1'b1, 1'b1, 1'b0, acc);
    check("flush_out_valid", 64'(out_valid), 0);
    check("flush_in_ready", 64'(in_ready), 1);
    repeat (4) idle(1'b1);
    check("flush_none_delivered", 64'(delivered - base), 0);
    cycle(4'b0000, 32'hF0, 32'h3C, 14, 1'b1, 1'b0, 1'b0, acc);
    cycle(4'b0001, 32'hF0, 32'h3C, 15, 1'b1, 1'b0, 1'b0, acc);
    in_valid = 0;
    #3 rst_n = 0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 0);
    check("async_rst_in_ready", 64'(in_ready), 1);
    check("async_rst_outputs", 64'({out_result, out_zero, out_ovf, out_illegal, out_dst}), 0);
    q.delete();
    #3 rst_n = 1;
    @(posedge clk) #1;
    for (int i = 0; i < 400; i++) begin
      logic [3:0] c;
      logic [31:0] a, b;
      c = ($urandom % 8 == 0) ? 4'($urandom) : legal[$urandom % 6];
      a = ($urandom % 3 == 0) ? edges[$urandom % 5] : $urandom;
      b = ($urandom % 3 == 0) ? edges[$urandom % 5] : $urandom;
      cycle(c, a, b, 5'($urandom), 1'($urandom % 4 != 0), 1'($urandom % 40 == 0),
            1'($urandom % 3 != 0), acc);
    end
    n = 0;
    while (q.size() > 0 && n < 10) begin idle(1'b1); n++; end
    check("drain_empty", 64'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
